// File: rtl/serdes_apb_cfg_master_if.sv
// serdes_apb_cfg_master_if: command/response port and APB3 bus of the SERDESIF config master
interface serdes_apb_cfg_master_if;
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic rsp_valid;
  logic [1:0] rsp_status;
  logic [31:0] rsp_rdata;
  logic [7:0] rsp_count;
  logic [11:0] apb_paddr;
  logic apb_psel;
  logic apb_penable;
  logic apb_pwrite;
  logic [31:0] apb_pwdata;
  logic [31:0] apb_prdata;
  logic apb_pready;
  logic apb_pslverr;
  modport master (
    input cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, apb_prdata, apb_pready, apb_pslverr,
    output cmd_ready, rsp_valid, rsp_status, rsp_rdata, rsp_count,
    output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, apb_prdata, apb_pready, apb_pslverr,
    input cmd_ready, rsp_valid, rsp_status, rsp_rdata, rsp_count,
    input apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata
  );
endinterface

// File: rtl/serdes_apb_cfg_master.sv
// serdes_apb_cfg_master: APB3 initiator running one WRITE/READ/POLL config command at a time
module serdes_apb_cfg_master #(
  parameter int POLL_MAX = 255,
  parameter int POLL_GAP = 15,
  parameter int WAIT_MAX = 1023
) (
  input logic apb_clk,
  input logic apb_rst,
  serdes_apb_cfg_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, DONE} state_t;
  state_t state, state_n;
  logic [1:0] op, status_n;
  logic [31:0] wdata, mask, rdata;
  logic [7:0] attempts, attempts_inc, gap_cnt;
  logic [15:0] wait_cnt;
  logic accept, is_write, is_poll, hit, abort, done_read;
  assign bus.cmd_ready = state == IDLE && !apb_rst;
  assign bus.apb_psel = state == SETUP || state == ACCESS;
  assign bus.apb_penable = state == ACCESS;
  assign bus.rsp_valid = state == DONE;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign is_write = op == 2'b00;
  assign is_poll = op == 2'b10;
  assign attempts_inc = attempts == 8'hff ? attempts : attempts + 8'd1;
  assign hit = ((bus.apb_prdata ^ wdata) & mask) == 32'd0;
  assign abort = !bus.apb_pready && wait_cnt == 16'(WAIT_MAX - 1);
  assign done_read = state == ACCESS && bus.apb_pready && !is_write;
  always_comb begin
    state_n = state;
    status_n = 2'b00;
    case (state)
      IDLE: state_n = accept ? SETUP : IDLE;
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (abort) begin
          state_n = DONE;
          status_n = 2'b10;
        end else if (bus.apb_pready) begin
          if (bus.apb_pslverr) begin
            state_n = DONE;
            status_n = 2'b01;
          end else if (!is_poll || hit) begin
            state_n = DONE;
          end else if (attempts_inc == 8'(POLL_MAX)) begin
            state_n = DONE;
            status_n = 2'b11;
          end else begin
            state_n = POLL_GAP == 0 ? SETUP : GAP;
          end
        end
      end
      GAP: state_n = gap_cnt == 8'(POLL_GAP - 1) ? SETUP : GAP;
      default: state_n = IDLE;
    endcase
  end
  // Bus address/data stay latched from acceptance, so they are stable for the whole transfer
  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      state <= IDLE;
      op <= 2'b00;
      wdata <= 32'd0;
      mask <= 32'd0;
      rdata <= 32'd0;
      attempts <= 8'd0;
      gap_cnt <= 8'd0;
      wait_cnt <= 16'd0;
      bus.apb_paddr <= 12'd0;
      bus.apb_pwrite <= 1'b0;
      bus.apb_pwdata <= 32'd0;
      bus.rsp_status <= 2'b00;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_count <= 8'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        op <= bus.cmd_op;
        wdata <= bus.cmd_wdata;
        mask <= bus.cmd_mask;
        rdata <= 32'd0;
        attempts <= 8'd0;
        bus.apb_paddr <= bus.cmd_addr;
        bus.apb_pwrite <= bus.cmd_op == 2'b00;
        bus.apb_pwdata <= bus.cmd_op == 2'b00 ? bus.cmd_wdata : 32'd0;
      end
      wait_cnt <= state == ACCESS && !bus.apb_pready ? wait_cnt + 16'd1 : 16'd0;
      gap_cnt <= state == GAP ? gap_cnt + 8'd1 : 8'd0;
      if (done_read) begin
        rdata <= bus.apb_prdata;
        attempts <= attempts_inc;
      end
      if (state == ACCESS && state_n == DONE) begin
        bus.rsp_status <= status_n;
        bus.rsp_rdata <= done_read ? bus.apb_prdata : rdata;
        bus.rsp_count <= done_read ? attempts_inc : attempts;
      end
    end
  end
endmodule

// File: tb/tb_serdes_apb_cfg_master.sv
// tb_serdes_apb_cfg_master: directed commands against an APB slave model, responses checked via scoreboard
module tb_serdes_apb_cfg_master;
  typedef struct packed {
    logic [1:0] status;
    logic [31:0] rdata;
    logic [7:0] count;
  } rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  rsp_t exp_q[$];
  int gap_q[$];
  int wait_states = 0, hang = 0, err = 0, match_at = 1, reads = 0, acc_cyc = 0, access_len = 0;
  logic [31:0] match_val = 32'd0, miss_val = 32'd0;
  logic [11:0] exp_paddr = 12'd0;
  logic exp_pwrite = 1'b0;
  logic [31:0] exp_pwdata = 32'd0;
  int t_acc = 0, psel_rise = 0, pen_rise = 0, rsp_cyc = 0, idle_run = 0;
  logic psel_prev = 1'b0, pen_prev = 1'b0;
  serdes_apb_cfg_master_if bus ();
  serdes_apb_cfg_master #(.POLL_MAX(4), .POLL_GAP(15), .WAIT_MAX(8)) dut (
    .apb_clk(clk),
    .apb_rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  // APB slave model: inputs change mid-cycle, away from the sampling edge
  always @(negedge clk) begin
    if (bus.apb_psel && bus.apb_penable) begin
      bus.apb_pready = hang == 0 && acc_cyc == wait_states;
      bus.apb_pslverr = err != 0 && bus.apb_pready;
      bus.apb_prdata = !bus.apb_pready ? 32'd0 : (reads + 1 >= match_at ? match_val : miss_val);
      if (bus.apb_pready && !bus.apb_pwrite) reads++;
      acc_cyc++;
      access_len = acc_cyc;
    end else begin
      bus.apb_pready = 1'b0;
      bus.apb_pslverr = 1'b0;
      bus.apb_prdata = 32'd0;
      acc_cyc = 0;
    end
  end
  // Monitor: bus timing bookkeeping, SETUP-phase checks and response scoreboard
  always @(negedge clk) begin
    if (bus.apb_psel) begin
      if (!psel_prev) begin
        gap_q.push_back(idle_run);
        psel_rise = cyc;
      end
      idle_run = 0;
      if (!bus.apb_penable) begin
        chk("setup_paddr", 32'(bus.apb_paddr), 32'(exp_paddr));
        chk("setup_pwrite", 32'(bus.apb_pwrite), 32'(exp_pwrite));
        chk("setup_pwdata", bus.apb_pwdata, exp_pwdata);
      end
    end else begin
      idle_run++;
    end
    if (bus.apb_penable && !pen_prev) pen_rise = cyc;
    psel_prev = bus.apb_psel;
    pen_prev = bus.apb_penable;
    if (bus.rsp_valid) begin
      rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_status", 32'(bus.rsp_status), 32'(e.status));
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_count", 32'(bus.rsp_count), 32'(e.count));
        chk("rsp_psel_low", 32'(bus.apb_psel), 32'd0);
      end
    end
  end
  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] mk, input bit want, input rsp_t e);
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_addr = addr;
    bus.cmd_wdata = wd;
    bus.cmd_mask = mk;
    exp_paddr = addr;
    exp_pwrite = op == 2'b00;
    exp_pwdata = op == 2'b00 ? wd : 32'd0;
    reads = 0;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
    t_acc = cyc;
    if (want) exp_q.push_back(e);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_addr = 12'd0;
    bus.cmd_wdata = 32'd0;
    bus.cmd_mask = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_psel", 32'(bus.apb_psel), 32'd0);
    chk("rst_penable", 32'(bus.apb_penable), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp", {bus.rsp_status, bus.rsp_rdata[21:0], bus.rsp_count}, 32'd0);
    chk("rst_apb", {bus.apb_paddr, bus.apb_pwrite, bus.apb_pwdata[18:0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    // 1: single write, zero wait states
    wait_states = 0;
    issue(2'b00, 12'h0A0, 32'hDEADBEEF, 32'd0, 1'b1, '{2'b00, 32'd0, 8'd0});
    wait_rsp();
    chk("wr_psel_delay", 32'(psel_rise - t_acc), 32'd1);
    chk("wr_penable_delay", 32'(pen_rise - t_acc), 32'd2);
    chk("wr_rsp_delay", 32'(rsp_cyc - t_acc), 32'd3);
    // 2: read with three wait states
    wait_states = 3;
    match_at = 1;
    match_val = 32'h12345678;
    issue(2'b01, 12'h004, 32'hFFFFFFFF, 32'd0, 1'b1, '{2'b00, 32'h12345678, 8'd1});
    wait_rsp();
    chk("rd_access_len", 32'(access_len), 32'd4);
    // 3: poll that matches on the third read
    wait_states = 0;
    match_at = 3;
    match_val = 32'hA5A50001;
    miss_val = 32'hA5A50000;
    gap_q.delete();
    issue(2'b10, 12'h010, 32'h00000001, 32'h00000001, 1'b1, '{2'b00, 32'hA5A50001, 8'd3});
    wait_rsp();
    chk("poll_reads", 32'(reads), 32'd3);
    chk("poll_gap_count", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
      chk("poll_gap1", 32'(gap_q[1]), 32'd15);
      chk("poll_gap2", 32'(gap_q[2]), 32'd15);
    end
    // 4: poll that never matches, bounded by POLL_MAX=4
    match_at = 1000;
    miss_val = 32'h00000010;
    issue(2'b10, 12'h020, 32'h000000F0, 32'h000000F0, 1'b1, '{2'b11, 32'h00000010, 8'd4});
    wait_rsp();
    chk("poll_to_reads", 32'(reads), 32'd4);
    // 5: hung slave aborts after WAIT_MAX=8, then a normal read
    hang = 1;
    issue(2'b00, 12'h123, 32'h00000055, 32'd0, 1'b1, '{2'b10, 32'd0, 8'd0});
    wait_rsp();
    chk("abort_access_len", 32'(access_len), 32'd8);
    hang = 0;
    match_at = 1;
    match_val = 32'hCAFEF00D;
    issue(2'b11, 12'hFFF, 32'd0, 32'd0, 1'b1, '{2'b00, 32'hCAFEF00D, 8'd1});
    wait_rsp();
    // 6: slave error on write, then reset in the middle of an access
    err = 1;
    issue(2'b00, 12'h044, 32'h0BADF00D, 32'd0, 1'b1, '{2'b01, 32'd0, 8'd0});
    wait_rsp();
    err = 0;
    wait_states = 6;
    issue(2'b01, 12'h055, 32'd0, 32'd0, 1'b0, '{2'b00, 32'd0, 8'd0});
    n = 0;
    while (!(bus.apb_psel && bus.apb_penable) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_access_reached", 32'(bus.apb_penable), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_psel", 32'(bus.apb_psel), 32'd0);
    chk("rst_async_penable", 32'(bus.apb_penable), 32'd0);
    chk("rst_async_ready", 32'(bus.cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (10) @(negedge clk);
    wait_states = 0;
    match_val = 32'h600DCAFE;
    issue(2'b01, 12'h066, 32'd0, 32'd0, 1'b1, '{2'b00, 32'h600DCAFE, 8'd1});
    wait_rsp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
